// File: rtl/estacionamiento_pkg.sv
// Shared types and helpers for the parking-gate sensor front end.
// Holds the passage FSM encoding, the tick direction codes and the debounce counter sizing.
package estacionamiento_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IN1   = 3'd1,
        IN2   = 3'd2,
        IN3   = 3'd3,
        OUT1  = 3'd4,
        OUT2  = 3'd5,
        OUT3  = 3'd6,
        FAULT = 3'd7
    } state_t;

    localparam logic SIGN_IN  = 1'b1;
    localparam logic SIGN_OUT = 1'b0;

    // Bits needed to count from 0 up to cycles inclusive.
    function automatic int unsigned deb_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizer plus stability filter for one raw photo-barrier input.
// The filtered value only follows the synchronized input after DEB_CYCLES consecutive disagreeing cycles.
module sensor_debounce
    import estacionamiento_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CNT_W = deb_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Metastability chain, raw enters at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Accept the new level on the edge the counter would reach DEB_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            filtered <= 1'b0;
        end else if (sync_bit == filtered) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            filtered <= sync_bit;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sensor_fsm_estacionamiento.sv
// Parking-gate passage tracker: conditions beams a/b and emits one tick per completed passage.
// sign qualifies tick (entry or exit); aborted, reversed or illegal sequences never tick.
module sensor_fsm_estacionamiento
    import estacionamiento_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic tick,
    output logic sign,
    output logic busy,
    output logic error
);

    logic       fa;
    logic       fb;
    logic [1:0] fab;
    state_t     state;
    state_t     next_state;
    logic       tick_c;
    logic       sign_c;
    logic       busy_c;
    logic       error_c;

    sensor_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_deb_a (
        .clk     (clk),
        .rst     (rst),
        .raw     (a),
        .filtered(fa)
    );

    sensor_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_deb_b (
        .clk     (clk),
        .rst     (rst),
        .raw     (b),
        .filtered(fb)
    );

    assign fab = {fa, fb};

    // State and output registers; outputs are decoded from next_state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tick  <= 1'b0;
            sign  <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= next_state;
            tick  <= tick_c;
            sign  <= sign_c;
            busy  <= busy_c;
            error <= error_c;
        end
    end

    // Passage tracking: entry walks 10,11,01,00; exit walks 01,11,10,00.
    always_comb begin
        next_state = state;
        tick_c     = 1'b0;
        sign_c     = sign;

        case (state)
            IDLE: begin
                case (fab)
                    2'b10:   next_state = IN1;
                    2'b01:   next_state = OUT1;
                    2'b11:   next_state = FAULT;
                    default: next_state = IDLE;
                endcase
            end
            IN1: begin
                case (fab)
                    2'b11:   next_state = IN2;
                    2'b00:   next_state = IDLE;
                    2'b01:   next_state = FAULT;
                    default: next_state = IN1;
                endcase
            end
            IN2: begin
                case (fab)
                    2'b01:   next_state = IN3;
                    2'b10:   next_state = IN1;
                    2'b00:   next_state = FAULT;
                    default: next_state = IN2;
                endcase
            end
            IN3: begin
                case (fab)
                    2'b00: begin
                        next_state = IDLE;
                        tick_c     = 1'b1;
                        sign_c     = SIGN_IN;
                    end
                    2'b11:   next_state = IN2;
                    2'b10:   next_state = FAULT;
                    default: next_state = IN3;
                endcase
            end
            OUT1: begin
                case (fab)
                    2'b11:   next_state = OUT2;
                    2'b00:   next_state = IDLE;
                    2'b10:   next_state = FAULT;
                    default: next_state = OUT1;
                endcase
            end
            OUT2: begin
                case (fab)
                    2'b10:   next_state = OUT3;
                    2'b01:   next_state = OUT1;
                    2'b00:   next_state = FAULT;
                    default: next_state = OUT2;
                endcase
            end
            OUT3: begin
                case (fab)
                    2'b00: begin
                        next_state = IDLE;
                        tick_c     = 1'b1;
                        sign_c     = SIGN_OUT;
                    end
                    2'b11:   next_state = OUT2;
                    2'b01:   next_state = FAULT;
                    default: next_state = OUT3;
                endcase
            end
            FAULT: begin
                if (fab == 2'b00) begin
                    next_state = IDLE;
                end
            end
            default: next_state = FAULT;
        endcase

        busy_c  = (next_state != IDLE) && (next_state != FAULT);
        error_c = (next_state == FAULT);
    end

endmodule

// File: tb/tb_sensor_fsm_estacionamiento.sv
// Directed bench for the parking-gate sensor FSM: a table of held input segments with
// expected tick/sign/busy/error, plus hand sequences for latency, glitch and async reset.
module tb_sensor_fsm_estacionamiento;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic tick;
    logic sign;
    logic busy;
    logic error;

    int errors = 0;
    int checks = 0;
    int tick_total = 0;
    int adjacent = 0;
    logic prev_tick = 1'b0;

    typedef struct {
        logic a;
        logic b;
        int   hold;
        int   exp_ticks;
        logic exp_sign;
        logic exp_busy;
        logic exp_error;
    } vec_t;

    vec_t vecs[$];

    sensor_fsm_estacionamiento #(
        .DEB_CYCLES (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .tick (tick),
        .sign (sign),
        .busy (busy),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick monitor: total pulses and any back-to-back pair.
    always @(negedge clk) begin
        if (tick === 1'b1) tick_total++;
        if (tick === 1'b1 && prev_tick === 1'b1) adjacent++;
        prev_tick = tick;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic va, input logic vb, input int et, input logic es,
                       input logic eb, input logic ee);
        vec_t v;
        v.a = va; v.b = vb; v.hold = 10;
        v.exp_ticks = et; v.exp_sign = es; v.exp_busy = eb; v.exp_error = ee;
        vecs.push_back(v);
    endtask

    task automatic hold_in(input logic va, input logic vb, input int n);
        a = va;
        b = vb;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        int first;
        logic after;
        int busy_hits;

        a = 1'b0; b = 1'b0; rst = 1'b1;

        //        a     b     ticks sign  busy  error
        add(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);  // idle
        add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);  // entry
        add(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);  // exit
        add(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);  // abort
        add(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);  // reverse then complete
        add(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1);  // illegal diagonal
        add(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);  // exit after fault
        add(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);  // clean entry
        add(1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0);  // exit leaves sign=0
        add(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("reset_tick",  int'(tick),  0);
        check("reset_sign",  int'(sign),  0);
        check("reset_busy",  int'(busy),  0);
        check("reset_error", int'(error), 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            base = tick_total;
            hold_in(vecs[i].a, vecs[i].b, vecs[i].hold);
            check($sformatf("v%0d_ticks", i), tick_total - base, vecs[i].exp_ticks);
            check($sformatf("v%0d_sign", i),  int'(sign),  int'(vecs[i].exp_sign));
            check($sformatf("v%0d_busy", i),  int'(busy),  int'(vecs[i].exp_busy));
            check($sformatf("v%0d_error", i), int'(error), int'(vecs[i].exp_error));
        end

        // Latency: tick in the cycle starting 7 rising edges after 00, one cycle wide.
        hold_in(1'b1, 1'b0, 10);
        hold_in(1'b1, 1'b1, 10);
        hold_in(1'b0, 1'b1, 10);
        a = 1'b0; b = 1'b0;
        first = 0;
        after = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (first != 0 && k == first + 1) after = tick;
            if (first == 0 && tick === 1'b1) first = k;
        end
        check("latency_edges", first, 7);
        check("tick_width", int'(after), 0);
        check("latency_sign", int'(sign), 1);
        @(negedge clk);

        // Glitch shorter than the debounce window never reaches the FSM.
        base = tick_total;
        busy_hits = 0;
        a = 1'b1;
        repeat (3) @(negedge clk);
        a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_hits++;
        end
        check("glitch_busy", busy_hits, 0);
        check("glitch_ticks", tick_total - base, 0);

        // Async reset while in IN3 clears everything without waiting for a clock.
        hold_in(1'b1, 1'b0, 10);
        hold_in(1'b1, 1'b1, 10);
        hold_in(1'b0, 1'b1, 10);
        check("pre_reset_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_tick",  int'(tick),  0);
        check("async_sign",  int'(sign),  0);
        check("async_busy",  int'(busy),  0);
        check("async_error", int'(error), 0);
        a = 1'b0; b = 1'b0;
        repeat (3) @(negedge clk);
        base = tick_total;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_ticks", tick_total - base, 0);
        check("post_reset_busy", int'(busy), 0);

        check("adjacent_ticks", adjacent, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
